// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types and constants for the intersection phase scheduler:
// state encoding, lamp one-hot patterns and default interval lengths.
package tlc_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    AR_MS  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    AR_SM  = 3'd5,
    WALK   = 3'd6
  } state_t;

  // Lamp vectors are packed as {green, yellow, red}
  typedef logic [2:0] lamp_t;
  localparam lamp_t RED    = 3'b001;
  localparam lamp_t YELLOW = 3'b010;
  localparam lamp_t GREEN  = 3'b100;

  localparam int GREEN_MIN_DEF = 8;
  localparam int GREEN_MAX_DEF = 20;
  localparam int YELLOW_T_DEF  = 3;
  localparam int ALLRED_T_DEF  = 2;
  localparam int WALK_T_DEF    = 6;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Saturating phase timer: cleared on every phase entry, flags once the
// count has reached the limit selected for the current phase.
module phase_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);

  localparam logic [W-1:0] COUNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != COUNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count >= limit);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Right-of-way authority for a main/side intersection with a pedestrian
// crossing: phase FSM, latched pedestrian request and registered lamps.
module intersection_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int GREEN_MAX = GREEN_MAX_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF,
  parameter int WALK_T    = WALK_T_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_btn,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state
);

  localparam int MAX_PARAM = max_of(max_of(max_of(GREEN_MIN, GREEN_MAX),
                                           max_of(YELLOW_T, ALLRED_T)), WALK_T);
  localparam int TW = $clog2(MAX_PARAM) + 1;

  localparam logic [TW-1:0] GMIN_L  = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_L  = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_L   = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_L    = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WALK_L  = TW'(WALK_T - 1);

  state_t          cur_state;
  state_t          nxt_state;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   limit;
  logic            at_limit;
  logic            ped_pending;
  logic            entering_walk;
  lamp_t           main_lamp;
  lamp_t           side_lamp;
  lamp_t           main_nxt;
  lamp_t           side_nxt;
  logic            walk_lamp;
  logic            walk_nxt;
  logic            ack_reg;
  logic            ack_nxt;

  always_comb begin
    limit = GMIN_L;
    case (cur_state)
      MAIN_G:         limit = GMIN_L;
      MAIN_Y, SIDE_Y: limit = YEL_L;
      AR_MS, AR_SM:   limit = AR_L;
      SIDE_G:         limit = GMAX_L;
      WALK:           limit = WALK_L;
      default:        limit = GMIN_L;
    endcase
  end

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (nxt_state != cur_state),
    .enable   (1'b1),
    .limit    (limit),
    .count    (timer),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= MAIN_G;
      main_lamp <= GREEN;
      side_lamp <= RED;
      walk_lamp <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      main_lamp <= main_nxt;
      side_lamp <= side_nxt;
      walk_lamp <= walk_nxt;
      ack_reg   <= ack_nxt;
    end
  end

  // Pedestrians beat side traffic at the all-red decision point.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      MAIN_G: if (at_limit && (side_req || ped_pending)) nxt_state = MAIN_Y;
      MAIN_Y: if (at_limit) nxt_state = AR_MS;
      AR_MS:  if (at_limit) nxt_state = ped_pending ? WALK : SIDE_G;
      SIDE_G: if (at_limit || ((timer >= GMIN_L) && !side_req)) nxt_state = SIDE_Y;
      SIDE_Y: if (at_limit) nxt_state = AR_SM;
      WALK:   if (at_limit) nxt_state = AR_SM;
      AR_SM:  if (at_limit) nxt_state = MAIN_G;
      default: nxt_state = MAIN_G;
    endcase
  end

  assign entering_walk = (nxt_state == WALK) && (cur_state != WALK);

  always_comb begin
    main_nxt = RED;
    side_nxt = RED;
    walk_nxt = 1'b0;
    ack_nxt  = entering_walk;
    case (nxt_state)
      MAIN_G:  main_nxt = GREEN;
      MAIN_Y:  main_nxt = YELLOW;
      SIDE_G:  side_nxt = GREEN;
      SIDE_Y:  side_nxt = YELLOW;
      WALK:    walk_nxt = 1'b1;
      default: ;
    endcase
  end

  // Clearing on WALK entry deliberately overrides a press in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || entering_walk) begin
      ped_pending <= 1'b0;
    end else if (ped_btn && (cur_state != WALK)) begin
      ped_pending <= 1'b1;
    end
  end

  assign {main_green, main_yellow, main_red} = main_lamp;
  assign {side_green, side_yellow, side_red} = side_lamp;
  assign walk    = walk_lamp;
  assign ped_ack = ack_reg;
  assign state   = cur_state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: stimulus queues the expected phase sequence, a negedge
// monitor measures each completed phase and checks lamps every cycle.
module tb_intersection_phase_scheduler;
  import tlc_pkg::*;

  typedef struct {
    logic [2:0] st;
    int         len;
  } phase_t;

  localparam logic [10:0] MAIN_REST = {3'd0, 3'b100, 3'b001, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       reset;
  logic       side_req;
  logic       ped_btn;
  logic       main_red, main_yellow, main_green;
  logic       side_red, side_yellow, side_green;
  logic       walk;
  logic       ped_ack;
  logic [2:0] state;

  logic       rst_prev = 1'b0;
  logic       mon_en = 1'b0;
  logic [2:0] cur_st;
  int         cur_len;
  phase_t     exp_q[$];
  int         checks = 0;
  int         errors = 0;

  intersection_phase_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .side_req    (side_req),
    .ped_btn     (ped_btn),
    .main_red    (main_red),
    .main_yellow (main_yellow),
    .main_green  (main_green),
    .side_red    (side_red),
    .side_yellow (side_yellow),
    .side_green  (side_green),
    .walk        (walk),
    .ped_ack     (ped_ack),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_prev <= reset;

  function automatic string st_name(input logic [2:0] s);
    case (s)
      3'd0: return "MAIN_G";
      3'd1: return "MAIN_Y";
      3'd2: return "AR_MS";
      3'd3: return "SIDE_G";
      3'd4: return "SIDE_Y";
      3'd5: return "AR_SM";
      3'd6: return "WALK";
      default: return "BAD";
    endcase
  endfunction

  // Phase bookkeeping and per-cycle lamp checks, sampled mid-cycle.
  always @(negedge clk) begin
    phase_t     e;
    logic [6:0] want_lamps;
    logic [6:0] got_lamps;
    logic       want_ack;
    if (rst_prev) begin
      mon_en  = 1'b1;
      cur_st  = 3'(MAIN_G);
      cur_len = 1;
    end else if (mon_en) begin
      if (state == cur_st) begin
        cur_len++;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_phase: %s ended after %0d cycles into %s, required no phase change",
                   st_name(cur_st), cur_len, st_name(state));
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (e.st != cur_st) begin
            errors++;
            $display("[TB] FAIL phase_state: got %s, required %s", st_name(cur_st), st_name(e.st));
          end
          checks++;
          if (e.len != cur_len) begin
            errors++;
            $display("[TB] FAIL phase_len %s: got %0d cycles, required %0d", st_name(cur_st), cur_len, e.len);
          end
        end
        cur_st  = state;
        cur_len = 1;
      end
    end
    if (mon_en) begin
      want_lamps[6:4] = (state == 3'(MAIN_G)) ? 3'b100 : (state == 3'(MAIN_Y)) ? 3'b010 : 3'b001;
      want_lamps[3:1] = (state == 3'(SIDE_G)) ? 3'b100 : (state == 3'(SIDE_Y)) ? 3'b010 : 3'b001;
      want_lamps[0]   = (state == 3'(WALK));
      got_lamps = {main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk};
      checks++;
      if (got_lamps !== want_lamps) begin
        errors++;
        $display("[TB] FAIL lamps in %s: got %b, required %b", st_name(state), got_lamps, want_lamps);
      end
      checks++;
      if ((!main_red && !side_red) || (walk && !(main_red && side_red))) begin
        errors++;
        $display("[TB] FAIL invariant: main_red=%b side_red=%b walk=%b, required a red road and red both during walk",
                 main_red, side_red, walk);
      end
      want_ack = (state == 3'(WALK)) && (cur_len == 1) && !rst_prev;
      checks++;
      if (ped_ack !== want_ack) begin
        errors++;
        $display("[TB] FAIL ped_ack in %s cycle %0d: got %b, required %b", st_name(state), cur_len, ped_ack, want_ack);
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that sampled reset.
  task automatic applyReset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    side_req = 1'b0;
    ped_btn  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    side_req = s;
    ped_btn  = p;
  endtask

  task automatic pushPhase(input state_t s, input int n);
    exp_q.push_back('{st: 3'(s), len: n});
  endtask

  task automatic checkOutput(input string name, input logic [10:0] want);
    logic [10:0] got;
    got = {state, main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk, ped_ack};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0) && (i < budget)) begin
      @(posedge clk);
      i++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s drain: %0d phases pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    reset    = 1'b1;
    side_req = 1'b0;
    ped_btn  = 1'b0;

    $display("[TB] idle");
    applyReset();
    checkOutput("idle_reset", MAIN_REST);
    stepCycles(60);
    checkOutput("idle_60", MAIN_REST);
    waitDrain("idle", 5);

    $display("[TB] side hold");
    applyReset();
    checkOutput("hold_reset", MAIN_REST);
    pushPhase(MAIN_G, 8);  pushPhase(MAIN_Y, 3); pushPhase(AR_MS, 2);
    pushPhase(SIDE_G, 20); pushPhase(SIDE_Y, 3); pushPhase(AR_SM, 2);
    pushPhase(MAIN_G, 8);
    applyStimulus(1'b1, 1'b0);
    waitDrain("hold", 150);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] gap-out early");
    applyReset();
    pushPhase(MAIN_G, 8); pushPhase(MAIN_Y, 3); pushPhase(AR_MS, 2);
    pushPhase(SIDE_G, 8); pushPhase(SIDE_Y, 3); pushPhase(AR_SM, 2);
    applyStimulus(1'b1, 1'b0);
    stepCycles(16);
    applyStimulus(1'b0, 1'b0);
    waitDrain("gap3", 100);
    stepCycles(5);
    checkOutput("gap3_rest", MAIN_REST);

    $display("[TB] gap-out late");
    applyReset();
    pushPhase(MAIN_G, 8);  pushPhase(MAIN_Y, 3); pushPhase(AR_MS, 2);
    pushPhase(SIDE_G, 13); pushPhase(SIDE_Y, 3); pushPhase(AR_SM, 2);
    applyStimulus(1'b1, 1'b0);
    stepCycles(25);
    applyStimulus(1'b0, 1'b0);
    waitDrain("gap12", 100);
    stepCycles(5);
    checkOutput("gap12_rest", MAIN_REST);

    $display("[TB] pedestrian");
    applyReset();
    pushPhase(MAIN_G, 8); pushPhase(MAIN_Y, 3); pushPhase(AR_MS, 2);
    pushPhase(WALK, 6);   pushPhase(AR_SM, 2);
    stepCycles(3);
    applyStimulus(1'b0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0);
    stepCycles(11);
    applyStimulus(1'b0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitDrain("ped", 100);
    stepCycles(30);
    checkOutput("ped_no_second_walk", MAIN_REST);

    $display("[TB] conflict");
    applyReset();
    pushPhase(MAIN_G, 8); pushPhase(MAIN_Y, 3); pushPhase(AR_MS, 2);
    pushPhase(WALK, 6);   pushPhase(AR_SM, 2);
    pushPhase(MAIN_G, 8); pushPhase(MAIN_Y, 3); pushPhase(AR_MS, 2);
    pushPhase(SIDE_G, 20); pushPhase(SIDE_Y, 3); pushPhase(AR_SM, 2);
    applyStimulus(1'b1, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0);
    waitDrain("conflict", 200);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] reset in side yellow");
    applyReset();
    pushPhase(MAIN_G, 8); pushPhase(MAIN_Y, 3); pushPhase(AR_MS, 2);
    pushPhase(SIDE_G, 20);
    applyStimulus(1'b1, 1'b0);
    stepCycles(20);
    applyStimulus(1'b1, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0);
    stepCycles(12);
    checkOutput("side_yellow_before_reset", {3'(SIDE_Y), 3'b001, 3'b010, 1'b0, 1'b0});
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    stepCycles(1);
    reset = 1'b0;
    checkOutput("mid_reset", MAIN_REST);
    waitDrain("mid_reset", 5);
    stepCycles(40);
    checkOutput("reset_drops_ped", MAIN_REST);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
